// File: rtl/ins_fetch_ctrl.sv
// Fetch/control-flow stage: captures the ROM word into the instruction register,
// resolves jumps, calls, returns and hardware loops, and steers the PC.
module ins_fetch_ctrl #(
  parameter int ADDR_W      = 10,
  parameter int INS_W       = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] addr_ins,
  input  logic [INS_W-1:0]  ins_data,
  input  logic              zero_flag,
  input  logic              stall,
  output logic [INS_W-1:0]  ir,
  output logic              ir_valid,
  output logic              pc_load,
  output logic [ADDR_W-1:0] jump_ins,
  output logic              stack_err
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
  localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  localparam logic [3:0] OP_HALT = 4'h0;
  localparam logic [3:0] OP_LDC  = 4'hA;
  localparam logic [3:0] OP_LOOP = 4'hB;
  localparam logic [3:0] OP_JMP  = 4'hC;
  localparam logic [3:0] OP_JZ   = 4'hD;
  localparam logic [3:0] OP_CALL = 4'hE;
  localparam logic [3:0] OP_RET  = 4'hF;

  logic [0:0]        state;
  logic [SP_W-1:0]   sp;
  logic [7:0]        count;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] ret_addr;
  logic [ADDR_W-1:0] top;
  logic [SP_W-1:0]   sp_dec;
  logic              stack_full;
  logic              stack_empty;
  logic              decode_en;

  logic              taken;
  logic [ADDR_W-1:0] dest;
  logic              push;
  logic              pop;
  logic              err_set;
  logic              ldc;
  logic              cnt_dec;

  assign opcode      = ins_data[15:12];
  assign target      = ADDR_W'(ins_data[9:0]);
  assign ret_addr    = addr_ins + ADDR_W'(1);
  assign sp_dec      = sp - 1'b1;
  assign top         = stack_mem[sp_dec[IDX_W-1:0]];
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == '0);
  assign decode_en   = (state == S_RUN) && !stall && !rst;

  always_comb begin
    taken   = 1'b0;
    dest    = target;
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    ldc     = 1'b0;
    cnt_dec = 1'b0;
    case (opcode)
      OP_JMP:  taken = 1'b1;
      OP_JZ:   taken = zero_flag;
      OP_CALL: begin
        // A call on a full stack still jumps; only the return address is lost.
        taken = 1'b1;
        if (stack_full) err_set = 1'b1;
        else            push    = 1'b1;
      end
      OP_RET: begin
        if (stack_empty) begin
          err_set = 1'b1;
        end else begin
          taken = 1'b1;
          pop   = 1'b1;
          dest  = top;
        end
      end
      OP_LOOP: begin
        if (count != 8'd0) begin
          taken   = 1'b1;
          cnt_dec = 1'b1;
        end
      end
      OP_LDC:  ldc = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (decode_en && push) stack_mem[sp[IDX_W-1:0]] <= ret_addr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      ir        <= '0;
      ir_valid  <= 1'b0;
      pc_load   <= 1'b0;
      jump_ins  <= '0;
      sp        <= '0;
      count     <= '0;
      stack_err <= 1'b0;
    end else if (state == S_HALT) begin
      pc_load  <= 1'b1;
      ir_valid <= 1'b0;
    end else if (stall) begin
      // Reload the current address so the PC holds until the stall lifts.
      pc_load  <= 1'b1;
      jump_ins <= addr_ins;
      ir_valid <= 1'b0;
    end else begin
      ir       <= ins_data;
      ir_valid <= 1'b1;
      if (opcode == OP_HALT) begin
        state    <= S_HALT;
        pc_load  <= 1'b1;
        jump_ins <= addr_ins;
      end else begin
        pc_load <= taken;
        if (taken) jump_ins <= dest;
      end
      if (push)      sp <= sp + 1'b1;
      else if (pop)  sp <= sp_dec;
      if (err_set)   stack_err <= 1'b1;
      if (ldc)          count <= ins_data[7:0];
      else if (cnt_dec) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_ins_fetch_ctrl.sv
// Bench for ins_fetch_ctrl: a ROM and falling-edge PC model surround the DUT; per-cycle
// expectations are queued as each input cycle is driven and compared after the edge.
module tb_ins_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addr_ins;
  logic [15:0] ins_data;
  logic        zero_flag;
  logic        stall;
  logic [15:0] ir;
  logic        ir_valid;
  logic        pc_load;
  logic [9:0]  jump_ins;
  logic        stack_err;

  logic [15:0] rom [0:1023];
  logic [9:0]  pc;

  typedef struct packed {
    logic [15:0] ir;
    logic        v;
    logic        pl;
    logic [9:0]  ji;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  ins_fetch_ctrl #(.ADDR_W(10), .INS_W(16), .STACK_DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .addr_ins  (addr_ins),
    .ins_data  (ins_data),
    .zero_flag (zero_flag),
    .stall     (stall),
    .ir        (ir),
    .ir_valid  (ir_valid),
    .pc_load   (pc_load),
    .jump_ins  (jump_ins),
    .stack_err (stack_err)
  );

  always #5 clk = ~clk;

  // PC model: advances on the falling edge, loading jump_ins when pc_load is set.
  always @(negedge clk) begin
    if (rst)          pc <= 10'd0;
    else if (pc_load) pc <= jump_ins;
    else              pc <= pc + 10'd1;
  end

  assign addr_ins = pc;
  assign ins_data = rom[pc];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic rom_clear();
    for (int i = 0; i < 1024; i++) rom[i] = 16'h1000 | 16'(i);
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    stall     = 1'b0;
    zero_flag = 1'b0;
    @(posedge clk);
    #1;
    check("rst_ir",        32'(ir),        32'h0);
    check("rst_ir_valid",  32'(ir_valid),  32'h0);
    check("rst_pc_load",   32'(pc_load),   32'h0);
    check("rst_jump_ins",  32'(jump_ins),  32'h0);
    check("rst_stack_err", 32'(stack_err), 32'h0);
    @(negedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Drive one cycle of inputs, queue what the DUT must show after the edge, then compare.
  task automatic step(input string tag, input logic s, input logic z,
                      input logic [15:0] e_ir, input logic e_v, input logic e_pl,
                      input logic [9:0] e_ji);
    exp_t e;
    stall     = s;
    zero_flag = z;
    exp_q.push_back('{ir: e_ir, v: e_v, pl: e_pl, ji: e_ji});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, ".ir"},       32'(ir),       32'(e.ir));
    check({tag, ".ir_valid"}, 32'(ir_valid), 32'(e.v));
    check({tag, ".pc_load"},  32'(pc_load),  32'(e.pl));
    if (e.pl) check({tag, ".jump_ins"}, 32'(jump_ins), 32'(e.ji));
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; zero_flag = 1'b0;

    // Plain words then JMP 0x155 at address 5.
    rom_clear();
    rom[5] = 16'hC155;
    do_reset();
    step("plain0", 0, 0, 16'h1000, 1, 0, 10'h000);
    step("plain1", 0, 0, 16'h1001, 1, 0, 10'h000);
    step("plain2", 0, 0, 16'h1002, 1, 0, 10'h000);
    step("plain3", 0, 0, 16'h1003, 1, 0, 10'h000);
    step("plain4", 0, 0, 16'h1004, 1, 0, 10'h000);
    step("jmp",    0, 0, 16'hC155, 1, 1, 10'h155);
    step("jmp_tgt",0, 0, 16'h1155, 1, 0, 10'h000);
    step("jmp_nx", 0, 0, 16'h1156, 1, 0, 10'h000);

    // CALL/RET, then five nested calls (overflow) and five returns (last not taken).
    rom_clear();
    rom[10'h000] = 16'hC010;
    rom[10'h010] = 16'hE200;
    rom[10'h200] = 16'hF000;
    rom[10'h011] = 16'hE100;
    rom[10'h100] = 16'hE110;
    rom[10'h110] = 16'hE120;
    rom[10'h120] = 16'hE130;
    rom[10'h130] = 16'hE140;
    rom[10'h140] = 16'hF000;
    rom[10'h121] = 16'hF000;
    rom[10'h111] = 16'hF000;
    rom[10'h101] = 16'hF000;
    rom[10'h012] = 16'hF000;
    do_reset();
    step("c_jmp",  0, 0, 16'hC010, 1, 1, 10'h010);
    step("call",   0, 0, 16'hE200, 1, 1, 10'h200);
    step("ret",    0, 0, 16'hF000, 1, 1, 10'h011);
    check("err_after_ret", 32'(stack_err), 32'h0);
    step("call1",  0, 0, 16'hE100, 1, 1, 10'h100);
    step("call2",  0, 0, 16'hE110, 1, 1, 10'h110);
    step("call3",  0, 0, 16'hE120, 1, 1, 10'h120);
    step("call4",  0, 0, 16'hE130, 1, 1, 10'h130);
    check("err_full_ok", 32'(stack_err), 32'h0);
    step("call5",  0, 0, 16'hE140, 1, 1, 10'h140);
    check("err_overflow", 32'(stack_err), 32'h1);
    step("ret1",   0, 0, 16'hF000, 1, 1, 10'h121);
    step("ret2",   0, 0, 16'hF000, 1, 1, 10'h111);
    step("ret3",   0, 0, 16'hF000, 1, 1, 10'h101);
    step("ret4",   0, 0, 16'hF000, 1, 1, 10'h012);
    step("ret5",   0, 0, 16'hF000, 1, 0, 10'h000);
    step("ret_fall", 0, 0, 16'h1013, 1, 0, 10'h000);

    // LDC 3, LOOP at 0x21 back to 0x20, then JZ not taken / taken.
    rom_clear();
    rom[10'h000] = 16'hA003;
    rom[10'h001] = 16'hC020;
    rom[10'h021] = 16'hB020;
    rom[10'h022] = 16'hD050;
    rom[10'h023] = 16'hD060;
    do_reset();
    step("ldc",    0, 0, 16'hA003, 1, 0, 10'h000);
    step("l_jmp",  0, 0, 16'hC020, 1, 1, 10'h020);
    for (int k = 0; k < 3; k++) begin
      step("loop_body",  0, 0, 16'h1020, 1, 0, 10'h000);
      step("loop_taken", 0, 0, 16'hB020, 1, 1, 10'h020);
    end
    step("loop_body",  0, 0, 16'h1020, 1, 0, 10'h000);
    step("loop_fall",  0, 0, 16'hB020, 1, 0, 10'h000);
    step("jz_nt",  0, 0, 16'hD050, 1, 0, 10'h000);
    step("jz_t",   0, 1, 16'hD060, 1, 1, 10'h060);
    step("jz_tgt", 0, 0, 16'h1060, 1, 0, 10'h000);

    // Stall over a JMP; stack and loop count must survive it.
    rom_clear();
    rom[10'h000] = 16'hE008;
    rom[10'h008] = 16'hA001;
    rom[10'h009] = 16'hC040;
    rom[10'h040] = 16'hB042;
    rom[10'h042] = 16'hF000;
    do_reset();
    step("s_call", 0, 0, 16'hE008, 1, 1, 10'h008);
    step("s_ldc",  0, 0, 16'hA001, 1, 0, 10'h000);
    for (int k = 0; k < 4; k++) step("stall", 1, 0, 16'hA001, 0, 1, 10'h009);
    step("s_rel",  0, 0, 16'hC040, 1, 1, 10'h040);
    step("s_loop", 0, 0, 16'hB042, 1, 1, 10'h042);
    step("s_ret",  0, 0, 16'hF000, 1, 1, 10'h001);
    step("s_fall", 0, 0, 16'h1001, 1, 0, 10'h000);
    check("stall_err", 32'(stack_err), 32'h0);

    // RET underflow, then HALT at 0x030, then reset out of HALT.
    rom_clear();
    rom[10'h000] = 16'hF000;
    rom[10'h001] = 16'hC030;
    rom[10'h030] = 16'h0ABC;
    do_reset();
    step("under",  0, 0, 16'hF000, 1, 0, 10'h000);
    check("err_underflow", 32'(stack_err), 32'h1);
    step("h_jmp",  0, 0, 16'hC030, 1, 1, 10'h030);
    step("halt",   0, 0, 16'h0ABC, 1, 1, 10'h030);
    for (int k = 0; k < 4; k++) step("halted", 0, 0, 16'h0ABC, 0, 1, 10'h030);
    check("halt_pc", 32'(addr_ins), 32'h030);
    do_reset();
    step("post_halt", 0, 0, 16'hF000, 1, 0, 10'h000);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
